// File: rtl/chip_io_ctrl_if.sv
// chip_io_ctrl_if: pad-side and core-side signal bundle of the I/O controller
interface chip_io_ctrl_if #(
   parameter int NUM_IN  = 3,
   parameter int NUM_OUT = 2
);
   logic [NUM_IN-1:0]  pad_din;
   logic               pad_ren;
   logic [NUM_IN-1:0]  core_in;
   logic               core_reset_n;
   logic [NUM_OUT-1:0] core_out;
   logic [NUM_OUT-1:0] pad_dout;
   logic [NUM_OUT-1:0] pad_oe;
   logic               loopback;
   logic               oe_off_req;
   logic               io_ready;
   modport slave (
      input  pad_din, core_out, loopback, oe_off_req,
      output pad_ren, core_in, core_reset_n, pad_dout, pad_oe, io_ready
   );
   modport master (
      output pad_din, core_out, loopback, oe_off_req,
      input  pad_ren, core_in, core_reset_n, pad_dout, pad_oe, io_ready
   );
endinterface

// File: rtl/chip_io_ctrl.sv
// chip_io_ctrl: pad I/O controller with reset/input sync and sequenced output enables
module chip_io_ctrl #(
   parameter int NUM_IN      = 3,
   parameter int NUM_OUT     = 2,
   parameter int SYNC_STAGES = 2,
   parameter int OE_DELAY    = 8
) (
   input logic             clk_i,
   input logic             rst_ni,
   chip_io_ctrl_if.slave   io
);
   localparam int CW = (OE_DELAY > 0) ? $clog2(OE_DELAY + 1) : 1;
   typedef enum logic [2:0] {RST, WAIT, ACTIVE, QUIESCE, OFF} state_e;
   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [SYNC_STAGES-1:0] rst_sync_q;
   logic [NUM_IN-1:0]  in_sync_q [SYNC_STAGES];
   logic               pad_ren_q, io_ready_q;
   logic [NUM_OUT-1:0] pad_dout_q, pad_dout_d, pad_oe_q, lb;
   assign io.pad_ren      = pad_ren_q;
   assign io.core_reset_n = rst_sync_q[SYNC_STAGES-1];
   assign io.core_in      = in_sync_q[SYNC_STAGES-1];
   assign io.pad_dout     = pad_dout_q;
   assign io.pad_oe       = pad_oe_q;
   assign io.io_ready     = io_ready_q;
   for (genvar j = 0; j < NUM_OUT; j++) begin : g_lb
      assign lb[j] = in_sync_q[SYNC_STAGES-1][j % NUM_IN];
   end
   // reset synchroniser and receiver enable: shift ones in after reset release
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rst_sync_q <= '0;
         pad_ren_q  <= 1'b0;
      end else begin
         rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
         pad_ren_q  <= 1'b1;
      end
   end
   // input synchroniser chain, no filtering
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < SYNC_STAGES; i++) in_sync_q[i] <= '0;
      end else begin
         in_sync_q[0] <= io.pad_din;
         for (int i = 1; i < SYNC_STAGES; i++) in_sync_q[i] <= in_sync_q[i-1];
      end
   end
   // bring-up / quiesce sequencer; leaves RST on the edge that releases core reset
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         RST: if (rst_sync_q[SYNC_STAGES-2]) begin
            state_d = WAIT;
            cnt_d   = '0;
         end
         WAIT: if (io.oe_off_req) state_d = OFF;
            else if (cnt_q == CW'(OE_DELAY)) state_d = ACTIVE;
            else cnt_d = cnt_q + 1'b1;
         ACTIVE: if (io.oe_off_req) begin
            state_d = QUIESCE;
            cnt_d   = '0;
         end
         QUIESCE: if (cnt_q == CW'(1)) state_d = OFF;
            else cnt_d = cnt_q + 1'b1;
         OFF: if (!io.oe_off_req) begin
            state_d = WAIT;
            cnt_d   = '0;
         end
         default: state_d = RST;
      endcase
      pad_dout_d = (state_d == ACTIVE) ? (io.loopback ? lb : io.core_out) : '0;
   end
   // state and registered outputs decoded from the next state
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= RST;
         cnt_q      <= '0;
         pad_oe_q   <= '0;
         io_ready_q <= 1'b0;
         pad_dout_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pad_oe_q   <= (state_d == ACTIVE || state_d == QUIESCE) ? '1 : '0;
         io_ready_q <= (state_d == ACTIVE);
         pad_dout_q <= pad_dout_d;
      end
   end
endmodule

// File: tb/tb_chip_io_ctrl.sv
// tb_chip_io_ctrl: scoreboard bench running OE_DELAY=8 and OE_DELAY=0 instances side by side
module tb_chip_io_ctrl;
   localparam int NI = 3, NO = 2, SYNC = 2;
   localparam int M_RST = 0, M_WAIT = 1, M_ACT = 2, M_QUI = 3, M_OFF = 4;
   typedef struct packed {
      logic          ren;
      logic          rn;
      logic [NI-1:0] cin;
      logic [NO-1:0] dout;
      logic [NO-1:0] oe;
      logic          rdy;
   } exp_t;
   typedef exp_t [1:0] pair_t;
   logic clk, rst_n;
   logic [NI-1:0] din;
   logic [NO-1:0] cout;
   logic lbk, off;
   int n_chk = 0, n_fail = 0;
   pair_t exp_q[$];
   int D[2] = '{8, 0};
   int since_rel = 0;
   logic [NI-1:0] din_log[$];
   int mode[2] = '{M_RST, M_RST};
   int wleft[2], qleft[2];
   chip_io_ctrl_if #(.NUM_IN(NI), .NUM_OUT(NO)) if0 ();
   chip_io_ctrl_if #(.NUM_IN(NI), .NUM_OUT(NO)) if1 ();
   assign if0.pad_din = din;  assign if1.pad_din = din;
   assign if0.core_out = cout; assign if1.core_out = cout;
   assign if0.loopback = lbk; assign if1.loopback = lbk;
   assign if0.oe_off_req = off; assign if1.oe_off_req = off;
   chip_io_ctrl #(.NUM_IN(NI), .NUM_OUT(NO), .SYNC_STAGES(SYNC), .OE_DELAY(8)) u0 (
      .clk_i(clk), .rst_ni(rst_n), .io(if0.slave));
   chip_io_ctrl #(.NUM_IN(NI), .NUM_OUT(NO), .SYNC_STAGES(SYNC), .OE_DELAY(0)) u1 (
      .clk_i(clk), .rst_ni(rst_n), .io(if1.slave));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(string nm, int k, logic [7:0] act, logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d at %0t: got %0h, want %0h", nm, k, $time, act, exp);
      end
   endtask
   task automatic cmp(int k, exp_t a, exp_t e);
      chk("pad_ren", k, 8'(a.ren), 8'(e.ren));
      chk("core_reset_n", k, 8'(a.rn), 8'(e.rn));
      chk("core_in", k, 8'(a.cin), 8'(e.cin));
      chk("pad_dout", k, 8'(a.dout), 8'(e.dout));
      chk("pad_oe", k, 8'(a.oe), 8'(e.oe));
      chk("io_ready", k, 8'(a.rdy), 8'(e.rdy));
   endtask
   function automatic exp_t act0();
      return {if0.pad_ren, if0.core_reset_n, if0.core_in, if0.pad_dout, if0.pad_oe, if0.io_ready};
   endfunction
   function automatic exp_t act1();
      return {if1.pad_ren, if1.core_reset_n, if1.core_in, if1.pad_dout, if1.pad_oe, if1.io_ready};
   endfunction
   // reference model: phase bookkeeping with countdowns, pushes expected outputs after each edge
   always @(posedge clk) begin
      pair_t e;
      logic [NI-1:0] cin_pre;
      e = '0;
      if (!rst_n) begin
         since_rel = 0;
         din_log.delete();
         for (int k = 0; k < 2; k++) mode[k] = M_RST;
      end else begin
         cin_pre = (din_log.size() == SYNC) ? din_log[0] : '0;
         since_rel++;
         din_log.push_back(din);
         if (din_log.size() > SYNC) void'(din_log.pop_front());
         for (int k = 0; k < 2; k++) begin
            case (mode[k])
               M_RST: if (since_rel >= SYNC) begin mode[k] = M_WAIT; wleft[k] = D[k] + 1; end
               M_WAIT: if (off) mode[k] = M_OFF;
                  else begin
                     wleft[k]--;
                     if (wleft[k] == 0) mode[k] = M_ACT;
                  end
               M_ACT: if (off) begin mode[k] = M_QUI; qleft[k] = 2; end
               M_QUI: begin
                  qleft[k]--;
                  if (qleft[k] == 0) mode[k] = M_OFF;
               end
               default: if (!off) begin mode[k] = M_WAIT; wleft[k] = D[k] + 1; end
            endcase
            e[k].ren = 1'b1;
            e[k].rn  = (since_rel >= SYNC);
            e[k].cin = (din_log.size() == SYNC) ? din_log[0] : '0;
            e[k].oe  = (mode[k] == M_ACT || mode[k] == M_QUI) ? '1 : '0;
            e[k].rdy = (mode[k] == M_ACT);
            if (mode[k] == M_ACT)
               for (int j = 0; j < NO; j++) e[k].dout[j] = lbk ? cin_pre[j % NI] : cout[j];
         end
      end
      exp_q.push_back(e);
   end
   // monitor: compare every presented output cycle against the scoreboard
   always @(negedge clk) begin
      pair_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         cmp(0, act0(), e[0]);
         cmp(1, act1(), e[1]);
      end
   end
   task automatic cyc(int n);
      repeat (n) begin
         @(negedge clk);
         #1;
         din  = NI'($urandom);
         cout = NO'($urandom);
      end
   endtask
   task automatic async_reset(int hold);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      cmp(0, act0(), '0);
      cmp(1, act1(), '0);
      cyc(hold);
      rst_n = 1'b1;
   endtask
   initial begin
      rst_n = 1'b0; din = '0; cout = '0; lbk = 1'b0; off = 1'b0;
      repeat (5) @(negedge clk);
      #1 rst_n = 1'b1;
      cyc(20);
      lbk = 1'b1;
      cyc(10);
      lbk = 1'b0;
      cyc(2);
      off = 1'b1;
      cyc(1);
      off = 1'b0;
      cyc(5);
      off = 1'b1;
      cyc(10);
      off = 1'b0;
      cyc(20);
      async_reset(5);
      cyc(25);
      repeat (500) begin
         if ($urandom_range(0, 99) == 0) async_reset($urandom_range(1, 4));
         off = ($urandom_range(0, 11) == 0) ? ~off : off;
         if ($urandom_range(0, 19) == 0) lbk = ~lbk;
         cyc(1);
      end
      off = 1'b0;
      cyc(3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/chip_io_ctrl.md
Name: chip_io_ctrl

Overview:
Parametrised pad-side I/O controller between the chip's pad ring (input receivers with R_EN, output drivers with EN) and the core block. It synchronises the external reset and all input channels, registers all output channels, and sequences output-driver enables after reset or on request. It also provides a loopback mode for pad-level test. It replaces per-signal hard-wired pad enables with a controlled bring-up and quiesce sequence.

Parameters:
NUM_IN, 3, number of input pad channels (>=1)
NUM_OUT, 2, number of output pad channels (>=1)
SYNC_STAGES, 2, synchroniser depth for reset and inputs (>=2)
OE_DELAY, 8, extra cycles in WAIT before drivers enable (>=0)

Ports:
clk  input  1  core clock, from input pad
reset  input  1  asynchronous, active-low reset, from input pad
pad_din  input  NUM_IN  raw values from input pad DOUT
pad_ren  output  1  receiver enable to all input pads R_EN
core_in  output  NUM_IN  synchronised inputs to core
core_reset_n  output  1  synchronised active-low reset to core
core_out  input  NUM_OUT  core output values
pad_dout  output  NUM_OUT  to output pad DIN
pad_oe  output  NUM_OUT  to output pad EN (all bits identical)
loopback  input  1  test mode: route synchronised inputs to outputs
oe_off_req  input  1  level request to quiesce and disable drivers
io_ready  output  1  high only in ACTIVE

Behaviour:
- Reset (reset low, async): pad_ren=0, core_in=0, core_reset_n=0, pad_dout=0, pad_oe=0, io_ready=0, all sync flops=0, FSM=RST, counter=0.
- Reset synchroniser: SYNC_STAGES flops shifting 1 in. core_reset_n asserts asynchronously and deasserts on the SYNC_STAGES-th rising clk edge after reset rises.
- pad_ren: goes to 1 on the first clk edge with reset high and stays 1 until reset.
- Input sync: each pad_din bit passes through SYNC_STAGES flops. core_in latency is SYNC_STAGES cycles. No glitch filtering.
- Output path: pad_dout is registered with 1-cycle latency.
  - In ACTIVE, normal mode: pad_dout <= core_out.
  - In ACTIVE, loopback=1: pad_dout[j] <= core_in[j mod NUM_IN].
  - In any other state: pad_dout <= 0.
  - A loopback change takes effect on the next edge.
- FSM, one transition per clk edge:
  - RST: leave to WAIT on the edge where core_reset_n is high. Counter=0.
  - WAIT: counter increments each cycle. If oe_off_req=1, go to OFF (priority). Else, when counter==OE_DELAY, go to ACTIVE. WAIT therefore lasts OE_DELAY+1 cycles. Counter width is clog2(OE_DELAY+1), minimum 1.
  - ACTIVE: pad_oe=all ones, io_ready=1. On oe_off_req=1, go to QUIESCE with counter=0.
  - QUIESCE: pad_oe stays all ones, pad_dout forced 0, io_ready=0. Lasts exactly 2 cycles, then OFF. oe_off_req dropping mid-QUIESCE does not abort it.
  - OFF: pad_oe=0, pad_dout=0. When oe_off_req=0, go to WAIT with counter=0.
- pad_oe and io_ready are registered outputs decoded from the next state, so they change on the same edge the state changes.
- Reset mid-operation from any state: all outputs drop to reset values immediately and asynchronously, and the full bring-up sequence reruns.
- No combinational path from any input to any output.

Test Plan:
- Reset release (defaults): hold reset low 5 cycles, then release. Required: pad_ren=1 after edge 1; core_reset_n=1 after edge 2; pad_oe=11 and io_ready=1 exactly 9 cycles after core_reset_n rises; pad_dout=00 before that.
- Input latency: with ACTIVE, toggle pad_din=101 -> core_in=101 exactly 2 edges later. Pulse pad_din[1] for 1 cycle -> core_in[1] pulses 1 cycle, delayed 2 edges.
- Output path: in ACTIVE, core_out=10 -> pad_dout=10 next edge. Set loopback=1 with core_in=011 -> pad_dout=11 next edge (j=0->in0, j=1->in1).
- Quiesce: in ACTIVE, assert oe_off_req for 1 cycle only. Required: io_ready=0 and pad_dout=00 on next edge; pad_oe=11 for 2 cycles, then 00; then WAIT for 9 cycles and back to ACTIVE.
- Off during WAIT: assert oe_off_req at WAIT counter=3. Required: OFF next edge with pad_oe=00. Hold the request 10 cycles -> stays OFF. Release -> full 9-cycle WAIT.
- Async reset mid-ACTIVE: drop reset between clk edges. Required: all outputs 0 without waiting for a clk edge; bring-up repeats as in scenario 1. Also repeat with OE_DELAY=0: WAIT lasts 1 cycle.
